// File: rtl/layer_norm_arbiter.sv
// layer_norm_arbiter: round-robin sharing of one layer_norm engine between
// NUM_REQ requesters. Latches the winner's operands, runs the engine's
// start/done protocol and hands the result back over valid/ready.
// Optional watchdog: define LN_ARB_TIMEOUT_EN to abort a stalled engine after
// TIMEOUT_CYCLES and return resp_err=1 with zero data.
module layer_norm_arbiter #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned SEQ_LEN        = 16,
  parameter int unsigned EMB_DIM        = 32,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned XW  = DATA_WIDTH * SEQ_LEN * EMB_DIM,
  localparam int unsigned PW  = DATA_WIDTH * EMB_DIM,
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*XW-1:0] req_x,
  input  logic [NUM_REQ*PW-1:0] req_gamma,
  input  logic [NUM_REQ*PW-1:0] req_beta,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [XW-1:0]         resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  ln_start,
  output logic [XW-1:0]         ln_x,
  output logic [PW-1:0]         ln_gamma,
  output logic [PW-1:0]         ln_beta,
  input  logic                  ln_done,
  input  logic [XW-1:0]         ln_x_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic                 busy_q, busy_d;
  logic                 ln_start_q, ln_start_d;
  logic [XW-1:0]        ln_x_q, ln_x_d;
  logic [PW-1:0]        ln_gamma_q, ln_gamma_d;
  logic [PW-1:0]        ln_beta_q, ln_beta_d;
  logic [XW-1:0]        resp_data_q, resp_data_d;

  logic                 win_found_c;
  logic [IDW-1:0]       win_id_c;

  logic [XW-1:0]        x_slot [NUM_REQ];
  logic [PW-1:0]        g_slot [NUM_REQ];
  logic [PW-1:0]        b_slot [NUM_REQ];

`ifdef LN_ARB_TIMEOUT_EN
  logic [31:0]          wd_cnt_q, wd_cnt_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Unpack the flat requester buses into per-slot views
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot_view
    assign x_slot[k] = req_x[k*XW +: XW];
    assign g_slot[k] = req_gamma[k*PW +: PW];
    assign b_slot[k] = req_beta[k*PW +: PW];
  end

  // Round-robin pick: first pending request scanning from rr_ptr upward
  always_comb begin
    logic [IDW-1:0] cand;
    win_found_c = 1'b0;
    win_id_c    = '0;
    cand        = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = IDW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
      if (!win_found_c && req_valid[cand]) begin
        win_found_c = 1'b1;
        win_id_c    = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs follow the state being entered
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    ln_x_d     = ln_x_q;
    ln_gamma_d = ln_gamma_q;
    ln_beta_d  = ln_beta_q;
    resp_data_d = resp_data_q;
    resp_err_d = resp_err_q;
`ifdef LN_ARB_TIMEOUT_EN
    wd_cnt_d   = wd_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found_c) begin
          state_d    = S_ISSUE;
          grant_d    = win_id_c;
          ln_x_d     = x_slot[win_id_c];
          ln_gamma_d = g_slot[win_id_c];
          ln_beta_d  = b_slot[win_id_c];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef LN_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (ln_done) begin
          state_d     = S_RESP;
          resp_data_d = ln_x_out;
          resp_err_d  = 1'b0;
        end
`ifdef LN_ARB_TIMEOUT_EN
        else if (wd_cnt_q >= 32'(TIMEOUT_CYCLES) - 32'd1) begin
          state_d     = S_RESP;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
`endif
      end
      S_RESP: begin
        if (resp_ready[grant_q]) begin
          state_d    = S_IDLE;
          resp_err_d = 1'b0;
          rr_ptr_d   = IDW'((int'(grant_q) + 1) % int'(NUM_REQ));
        end
      end
      default: state_d = S_IDLE;
    endcase

    ln_start_d   = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
    req_ready_d  = (state_d == S_ISSUE) ? (NUM_REQ'(1) << grant_d) : '0;
    resp_valid_d = (state_d == S_RESP)  ? (NUM_REQ'(1) << grant_d) : '0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      ln_start_q   <= 1'b0;
      ln_x_q       <= '0;
      ln_gamma_q   <= '0;
      ln_beta_q    <= '0;
      resp_data_q  <= '0;
`ifdef LN_ARB_TIMEOUT_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      ln_start_q   <= ln_start_d;
      ln_x_q       <= ln_x_d;
      ln_gamma_q   <= ln_gamma_d;
      ln_beta_q    <= ln_beta_d;
      resp_data_q  <= resp_data_d;
`ifdef LN_ARB_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign ln_start   = ln_start_q;
  assign ln_x       = ln_x_q;
  assign ln_gamma   = ln_gamma_q;
  assign ln_beta    = ln_beta_q;
  assign resp_data  = resp_data_q;

endmodule

// File: doc/layer_norm_arbiter.md
Name: layer_norm_arbiter

Overview:
- Shares one layer_norm engine between NUM_REQ requesters, e.g. the pre-attention LN and pre-MLP LN of each encoder block.
- Arbitrates round-robin and latches the winner's x/gamma/beta.
- Sequences the engine's start/done protocol, then returns the normalised tensor to the winner with a valid/ready handshake.
- Sits between the transformer-layer controllers and a single layer_norm instance.

Parameters:
- DATA_WIDTH, 16, element width (Q-format as the engine).
- SEQ_LEN, 16, tokens per tensor.
- EMB_DIM, 32, embedding dimension.
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 4096, watchdog limit (used only with the optional feature).
- Derived: XW = DATA_WIDTH*SEQ_LEN*EMB_DIM; PW = DATA_WIDTH*EMB_DIM; IDW = max(1, $clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request, held until req_ready.
- req_ready  out  NUM_REQ  one-hot 1-cycle grant/accept pulse.
- req_x  in  NUM_REQ*XW  per-requester input tensor; slot k at [k*XW +: XW].
- req_gamma  in  NUM_REQ*PW  per-requester gamma.
- req_beta  in  NUM_REQ*PW  per-requester beta.
- resp_valid  out  NUM_REQ  one-hot result valid.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  XW  result tensor, shared by all requesters.
- resp_err  out  1  result invalid (watchdog abort); 0 without the feature.
- busy  out  1  high in any state except S_IDLE.
- grant_id  out  IDW  index of the current owner.
- ln_start  out  1  engine start pulse.
- ln_x  out  XW  engine x_in.
- ln_gamma  out  PW  engine gamma_in.
- ln_beta  out  PW  engine beta_in.
- ln_done  in  1  engine done pulse.
- ln_x_out  in  XW  engine result; valid in the cycle ln_done=1.

Behaviour:
- Reset (rst=1 at posedge):
  - state=S_IDLE, rr_ptr=0.
  - req_ready, resp_valid, resp_err, busy, ln_start, grant_id = 0.
  - ln_x, ln_gamma, ln_beta, resp_data cleared to 0.
- Reset mid-operation aborts with no response. The integrator resets the engine on the same event.
- All outputs are registered.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
- S_IDLE:
  - If any req_valid: winner g = first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - At the edge: latch req_x/gamma/beta slot g into ln_x/ln_gamma/ln_beta, grant_id<=g, go to S_ISSUE.
- S_ISSUE (exactly 1 cycle): ln_start=1, req_ready[g]=1, busy=1; then go to S_WAIT.
- S_WAIT: ln_x/gamma/beta held constant. When ln_done=1: resp_data<=ln_x_out, go to S_RESP.
- ln_done is ignored outside S_WAIT.
- S_RESP:
  - resp_valid[g]=1; resp_data is stable.
  - When resp_ready[g]=1: resp_valid drops, rr_ptr<=(g+1) mod NUM_REQ, go to S_IDLE.
  - resp_ready of non-owners is ignored.
- Latency: req_valid seen in S_IDLE cycle T gives req_ready and ln_start at T+1. resp_valid follows 1 cycle after ln_done.
- Back-to-back: minimum of 1 S_IDLE cycle between RESP exit and the next grant.
- Requesters may deassert req_valid only after req_ready. A withdrawn request is simply not granted.
- Fairness: with all requesters asserting, the grant order is 0,1,..,N-1,0. No requester waits more than NUM_REQ-1 services.
- Simultaneous events:
  - The owner re-asserting req_valid during S_RESP is arbitrated normally in the next S_IDLE.
  - rst wins over everything.

Optional Feature:
- Macro: LN_ARB_TIMEOUT_EN.
- Enabled:
  - A 32-bit counter clears on S_ISSUE and increments in S_WAIT.
  - On reaching TIMEOUT_CYCLES without ln_done: go to S_RESP with resp_err=1 and resp_data=0.
  - resp_err clears when leaving S_RESP.
- Disabled: no counter; resp_err tied 0; S_WAIT waits indefinitely.

Test Plan:
- Test configuration: SEQ_LEN=2, EMB_DIM=2, NUM_REQ=2, real engine.
- Single request: req_valid[0] with x={1,2,3,4}, gamma=1, beta=0 -> req_ready[0] one pulse, ln_start one pulse, resp_valid=2'b01, resp_data equals engine ln_x_out; busy low after resp_ready.
- Contention: req_valid=2'b11 held continuously -> grants 0,1,0,1. resp_valid of requester 1 carries beta=5 results (req_beta[1]=5 applied).
- Backpressure: resp_ready[0] held 0 for 10 cycles -> resp_valid[0] and resp_data stable for all 10 cycles. No new grant issued.
- Operand isolation: change req_x[0] after req_ready -> ln_x unchanged through S_WAIT; result reflects the originally latched data.
- Reset in S_WAIT: rst=1 for 1 cycle -> next cycle all outputs 0, state S_IDLE, rr_ptr=0. A fresh request then completes normally.
- LN_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, engine stubbed with no ln_done -> resp_valid with resp_err=1 and resp_data=0 at cycle ISSUE+9.
